// File: rtl/framebuffer_mig_arbiter.sv
// Arbitrates one MIG app_* port between the camera write stream and the display read stream.
// Read returns land in a credit-limited buffer, so MIG read data is never dropped.
module framebuffer_mig_arbiter #(
    parameter int FRAME_PHRASES = 9600,
    parameter int ADDR_STRIDE   = 8,
    parameter int RD_DEPTH      = 16
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         calib_in,
    input  logic         wr_valid_in,
    output logic         wr_ready_out,
    input  logic [127:0] wr_data_in,
    input  logic         wr_tuser_in,
    output logic         rd_valid_out,
    input  logic         rd_ready_in,
    output logic [127:0] rd_data_out,
    output logic         rd_tuser_out,
    output logic [26:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    input  logic         app_rdy,
    output logic [127:0] app_wdf_data,
    output logic         app_wdf_wren,
    output logic         app_wdf_end,
    output logic [15:0]  app_wdf_mask,
    input  logic         app_wdf_rdy,
    input  logic [127:0] app_rd_data,
    input  logic         app_rd_data_valid
);
    localparam int IDX_W = $clog2(FRAME_PHRASES);
    localparam int CNT_W = $clog2(RD_DEPTH) + 1;
    localparam int PTR_W = $clog2(RD_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PHRASES - 1);

    typedef enum logic [1:0] {WAIT_CAL, ARB, WR, RD} state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   wr_idx_reg, rd_idx_reg, wr_index;
    logic               frame_ready_reg, wrote_any_reg, last_grant_rd_reg;
    logic [CNT_W-1:0]   outstanding_reg, occupancy_reg;
    logic [CNT_W:0]     credit_used;
    logic [PTR_W-1:0]   tag_wr_ptr_reg, tag_rd_ptr_reg, buf_wr_ptr_reg, buf_rd_ptr_reg;
    logic               tag_mem [RD_DEPTH];
    logic [128:0]       buf_mem [RD_DEPTH];
    logic               wr_req, rd_req, arb_ok, grant_wr, grant_rd;
    logic               cmd_done, data_done, rd_push, rd_pop;

    function automatic logic [26:0] idx_addr(input logic [IDX_W-1:0] idx);
        return 27'(idx) * 27'(ADDR_STRIDE);
    endfunction

    // Buffered phrases plus reads still in flight must never exceed the buffer depth.
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, occupancy_reg};
    assign wr_req      = wr_valid_in;
    assign rd_req      = frame_ready_reg && (credit_used < (CNT_W+1)'(RD_DEPTH));
    assign arb_ok      = (state_reg == ARB) && calib_in;
    assign grant_wr    = arb_ok && wr_req && (!rd_req || last_grant_rd_reg);
    assign grant_rd    = arb_ok && rd_req && !grant_wr;
    assign wr_index    = wr_tuser_in ? '0 : wr_idx_reg;

    assign cmd_done    = !app_en || app_rdy;
    assign data_done   = !app_wdf_wren || app_wdf_rdy;
    assign rd_push     = app_rd_data_valid;
    assign rd_pop      = rd_valid_out && rd_ready_in;

    assign wr_ready_out = grant_wr;
    assign rd_valid_out = (occupancy_reg != '0);
    assign rd_data_out  = rd_valid_out ? buf_mem[buf_rd_ptr_reg][127:0] : '0;
    assign rd_tuser_out = rd_valid_out ? buf_mem[buf_rd_ptr_reg][128] : 1'b0;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = '0;

    // Storage arrays carry no reset; validity comes from the pointers and counters.
    always_ff @(posedge clk_in) begin
        if (grant_rd)
            tag_mem[tag_wr_ptr_reg] <= (rd_idx_reg == '0);
        if (rd_push)
            buf_mem[buf_wr_ptr_reg] <= {tag_mem[tag_rd_ptr_reg], app_rd_data};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            outstanding_reg <= '0;
            occupancy_reg   <= '0;
            tag_wr_ptr_reg  <= '0;
            tag_rd_ptr_reg  <= '0;
            buf_wr_ptr_reg  <= '0;
            buf_rd_ptr_reg  <= '0;
        end else begin
            outstanding_reg <= outstanding_reg + CNT_W'(grant_rd) - CNT_W'(rd_push);
            occupancy_reg   <= occupancy_reg + CNT_W'(rd_push) - CNT_W'(rd_pop);
            if (grant_rd)
                tag_wr_ptr_reg <= tag_wr_ptr_reg + PTR_W'(1);
            if (rd_push) begin
                tag_rd_ptr_reg <= tag_rd_ptr_reg + PTR_W'(1);
                buf_wr_ptr_reg <= buf_wr_ptr_reg + PTR_W'(1);
            end
            if (rd_pop)
                buf_rd_ptr_reg <= buf_rd_ptr_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg         <= WAIT_CAL;
            wr_idx_reg        <= '0;
            rd_idx_reg        <= '0;
            frame_ready_reg   <= 1'b0;
            wrote_any_reg     <= 1'b0;
            last_grant_rd_reg <= 1'b1;
            app_addr          <= '0;
            app_cmd           <= '0;
            app_en            <= 1'b0;
            app_wdf_wren      <= 1'b0;
            app_wdf_data      <= '0;
        end else begin
            case (state_reg)
                WAIT_CAL: begin
                    if (calib_in)
                        state_reg <= ARB;
                end
                ARB: begin
                    if (!calib_in) begin
                        state_reg <= WAIT_CAL;
                    end else if (grant_wr) begin
                        app_addr          <= idx_addr(wr_index);
                        app_cmd           <= 3'b000;
                        app_en            <= 1'b1;
                        app_wdf_wren      <= 1'b1;
                        app_wdf_data      <= wr_data_in;
                        wr_idx_reg        <= (wr_index == LAST_IDX) ? '0 : wr_index + IDX_W'(1);
                        wrote_any_reg     <= 1'b1;
                        last_grant_rd_reg <= 1'b0;
                        // A completed frame is either a natural wrap or a new frame start.
                        if ((wr_index == LAST_IDX) || (wr_tuser_in && wrote_any_reg))
                            frame_ready_reg <= 1'b1;
                        state_reg <= WR;
                    end else if (grant_rd) begin
                        app_addr          <= idx_addr(rd_idx_reg);
                        app_cmd           <= 3'b001;
                        app_en            <= 1'b1;
                        rd_idx_reg        <= (rd_idx_reg == LAST_IDX) ? '0 : rd_idx_reg + IDX_W'(1);
                        last_grant_rd_reg <= 1'b1;
                        state_reg         <= RD;
                    end
                end
                WR: begin
                    if (app_en && app_rdy)
                        app_en <= 1'b0;
                    if (app_wdf_wren && app_wdf_rdy)
                        app_wdf_wren <= 1'b0;
                    if (cmd_done && data_done)
                        state_reg <= calib_in ? ARB : WAIT_CAL;
                end
                RD: begin
                    if (app_rdy) begin
                        app_en    <= 1'b0;
                        state_reg <= calib_in ? ARB : WAIT_CAL;
                    end
                end
                default: state_reg <= WAIT_CAL;
            endcase
        end
    end
endmodule

// File: tb/tb_framebuffer_mig_arbiter.sv
// Directed bench for framebuffer_mig_arbiter with a small MIG model that logs
// accepted commands and returns read data one cycle after each read handshake.
module tb_framebuffer_mig_arbiter;
    logic         clk_in = 1'b0;
    logic         rst_n_in = 1'b0;
    logic         calib_in = 1'b0;
    logic         wr_valid_in = 1'b0;
    logic         wr_ready_out;
    logic [127:0] wr_data_in = '0;
    logic         wr_tuser_in = 1'b0;
    logic         rd_valid_out;
    logic         rd_ready_in = 1'b0;
    logic [127:0] rd_data_out;
    logic         rd_tuser_out;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy = 1'b1;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_rdy = 1'b1;
    logic [127:0] app_rd_data = '0;
    logic         app_rd_data_valid = 1'b0;

    int total = 0;
    int bad = 0;

    logic [2:0]   log_cmd[$];
    logic [26:0]  log_addr[$];
    logic [127:0] log_wdata[$];
    logic [26:0]  ret_q[$];

    always #5 clk_in = ~clk_in;

    framebuffer_mig_arbiter dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .calib_in(calib_in),
        .wr_valid_in(wr_valid_in), .wr_ready_out(wr_ready_out),
        .wr_data_in(wr_data_in), .wr_tuser_in(wr_tuser_in),
        .rd_valid_out(rd_valid_out), .rd_ready_in(rd_ready_in),
        .rd_data_out(rd_data_out), .rd_tuser_out(rd_tuser_out),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid)
    );

    function automatic logic [127:0] mig_data(input logic [26:0] a);
        return {5'd0, a, 32'hFEED_0000, ~{5'd0, a}, 5'd0, a};
    endfunction

    function automatic logic [127:0] phrase(input int i);
        return {32'hCAFE_0000, 32'(i), 32'(i * 3), 32'h0000_1234};
    endfunction

    always @(posedge clk_in) begin
        if (rst_n_in) begin
            if (app_en && app_rdy) begin
                log_cmd.push_back(app_cmd);
                log_addr.push_back(app_addr);
                if (app_cmd == 3'b001)
                    ret_q.push_back(app_addr);
            end
            if (app_wdf_wren && app_wdf_rdy)
                log_wdata.push_back(app_wdf_data);
        end
    end

    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            ret_q.delete();
            app_rd_data_valid = 1'b0;
        end else if (ret_q.size() > 0) begin
            app_rd_data = mig_data(ret_q.pop_front());
            app_rd_data_valid = 1'b1;
        end else begin
            app_rd_data_valid = 1'b0;
        end
    end

    task automatic clear_logs();
        log_cmd.delete();
        log_addr.delete();
        log_wdata.delete();
    endtask

    task automatic send_write(input logic [127:0] d, input logic tu);
        bit acc;
        acc = 1'b0;
        @(negedge clk_in);
        wr_data_in = d;
        wr_tuser_in = tu;
        wr_valid_in = 1'b1;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (wr_ready_out === 1'b1) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        if (acc) begin
            @(posedge clk_in);
            #1;
        end
        wr_valid_in = 1'b0;
        wr_tuser_in = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL write_accept: got no wr_ready_out in 100 cycles want handshake");
        end
    endtask

    task automatic test_reset();
        #23;
        total++; if (wr_ready_out !== 1'b0) begin bad++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready_out); end
        total++; if (app_en !== 1'b0) begin bad++; $display("FAIL reset_app_en: got %b want 0", app_en); end
        total++; if (app_cmd !== 3'b000) begin bad++; $display("FAIL reset_app_cmd: got %b want 000", app_cmd); end
        total++; if (app_addr !== 27'd0) begin bad++; $display("FAIL reset_app_addr: got %0d want 0", app_addr); end
        total++; if ({app_wdf_wren, app_wdf_end} !== 2'b00) begin bad++; $display("FAIL reset_wren: got %b want 00", {app_wdf_wren, app_wdf_end}); end
        total++; if (app_wdf_mask !== 16'h0) begin bad++; $display("FAIL reset_mask: got %h want 0", app_wdf_mask); end
        total++; if (rd_valid_out !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid_out); end
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic test_calib();
        int cyc;
        clear_logs();
        @(negedge clk_in);
        wr_data_in = phrase(0);
        wr_tuser_in = 1'b1;
        wr_valid_in = 1'b1;
        for (int c = 0; c < 50; c++) begin
            #1;
            total++;
            if (wr_ready_out !== 1'b0 || app_en !== 1'b0) begin
                bad++;
                $display("FAIL calib_low_idle: got wr_ready=%b app_en=%b want 0 0 (cycle %0d)", wr_ready_out, app_en, c);
            end
            @(negedge clk_in);
        end
        calib_in = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk_in);
            #1;
            if (app_en === 1'b1) begin
                cyc = c;
                break;
            end
        end
        wr_valid_in = 1'b0;
        wr_tuser_in = 1'b0;
        total++; if (cyc < 1 || cyc > 2) begin bad++; $display("FAIL calib_first_write_latency: got %0d cycles want 1..2", cyc); end
        total++; if (app_addr !== 27'd0 || app_cmd !== 3'b000) begin bad++; $display("FAIL calib_first_write_cmd: got addr=%0d cmd=%b want 0 000", app_addr, app_cmd); end
        total++; if (app_wdf_data !== phrase(0)) begin bad++; $display("FAIL calib_first_write_data: got %h want %h", app_wdf_data, phrase(0)); end
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_stream();
        int first_bad;
        for (int i = 1; i < 9600; i++)
            send_write(phrase(i), 1'b0);
        repeat (80) @(negedge clk_in);
        total++;
        if (log_cmd.size() < 9600 || log_wdata.size() != 9600) begin
            bad++;
            $display("FAIL stream_count: got cmds=%0d wdata=%0d want >=9600 and 9600", log_cmd.size(), log_wdata.size());
        end else begin
            first_bad = -1;
            for (int i = 0; i < 9600; i++)
                if (log_cmd[i] !== 3'b000 || log_addr[i] !== 27'(i * 8) || log_wdata[i] !== phrase(i)) begin
                    first_bad = i;
                    break;
                end
            total++;
            if (first_bad >= 0) begin
                bad++;
                $display("FAIL stream_seq: at %0d got cmd=%b addr=%0d want 000 addr=%0d", first_bad, log_cmd[first_bad], log_addr[first_bad], first_bad * 8);
            end
            total++; if (log_addr[9599] !== 27'd76792) begin bad++; $display("FAIL stream_last_addr: got %0d want 76792", log_addr[9599]); end
        end
    endtask

    task automatic test_credit();
        int nrd;
        nrd = log_cmd.size() - 9600;
        total++; if (nrd != 16) begin bad++; $display("FAIL credit_read_count: got %0d want 16", nrd); end
        if (nrd >= 16)
            for (int k = 0; k < 16; k++) begin
                total++;
                if (log_cmd[9600 + k] !== 3'b001 || log_addr[9600 + k] !== 27'(k * 8)) begin
                    bad++;
                    $display("FAIL credit_read_addr: read %0d got cmd=%b addr=%0d want 001 addr=%0d", k, log_cmd[9600 + k], log_addr[9600 + k], k * 8);
                end
            end
        total++; if (rd_valid_out !== 1'b1) begin bad++; $display("FAIL credit_rd_valid: got %b want 1", rd_valid_out); end
    endtask

    task automatic test_pop_order();
        int got;
        got = 0;
        @(negedge clk_in);
        rd_ready_in = 1'b1;
        for (int c = 0; c < 400 && got < 24; c++) begin
            #1;
            if (rd_valid_out === 1'b1) begin
                total++;
                if (rd_data_out !== mig_data(27'(got * 8))) begin
                    bad++;
                    $display("FAIL pop_data: phrase %0d got %h want %h", got, rd_data_out, mig_data(27'(got * 8)));
                end
                total++;
                if (rd_tuser_out !== (got == 0)) begin
                    bad++;
                    $display("FAIL pop_tuser: phrase %0d got %b want %b", got, rd_tuser_out, got == 0);
                end
                got++;
            end
            @(negedge clk_in);
        end
        rd_ready_in = 1'b0;
        total++; if (got != 24) begin bad++; $display("FAIL pop_count: got %0d want 24", got); end
        repeat (80) @(negedge clk_in);
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_cmd;
        clear_logs();
        @(negedge clk_in);
        rd_ready_in = 1'b1;
        for (int w = 0; w < 4; w++)
            send_write(phrase(100 + w), 1'b0);
        repeat (4) @(negedge clk_in);
        rd_ready_in = 1'b0;
        repeat (80) @(negedge clk_in);
        total++;
        if (log_cmd.size() < 8) begin
            bad++;
            $display("FAIL alt_count: got %0d want >=8", log_cmd.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                exp_cmd = (k % 2 == 1) ? 3'b001 : 3'b000;
                total++;
                if (log_cmd[k] !== exp_cmd) begin
                    bad++;
                    $display("FAIL alt_order: cmd %0d got %b want %b", k, log_cmd[k], exp_cmd);
                end
            end
            total++; if (log_addr[0] !== 27'd0) begin bad++; $display("FAIL alt_first_addr: got %0d want 0", log_addr[0]); end
        end
        total++; if (log_wdata.size() < 1 || log_wdata[0] !== phrase(100)) begin bad++; $display("FAIL alt_first_data: got %0d entries want phrase 100 first", log_wdata.size()); end
    endtask

    task automatic test_wdf_delay();
        clear_logs();
        app_wdf_rdy = 1'b0;
        send_write(phrase(200), 1'b1);
        total++; if (app_en !== 1'b1 || app_wdf_wren !== 1'b1) begin bad++; $display("FAIL wdf_entry: got en=%b wren=%b want 1 1", app_en, app_wdf_wren); end
        total++; if (app_addr !== 27'd0) begin bad++; $display("FAIL wdf_tuser_addr: got %0d want 0", app_addr); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_in);
            #1;
            total++;
            if (app_en !== 1'b0 || app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1) begin
                bad++;
                $display("FAIL wdf_hold: cycle %0d got en=%b wren=%b end=%b want 0 1 1", c, app_en, app_wdf_wren, app_wdf_end);
            end
        end
        app_wdf_rdy = 1'b1;
        @(posedge clk_in);
        #1;
        total++; if (app_wdf_wren !== 1'b0 || app_en !== 1'b0) begin bad++; $display("FAIL wdf_release: got en=%b wren=%b want 0 0", app_en, app_wdf_wren); end
        repeat (5) @(negedge clk_in);
        total++; if (log_cmd.size() != 1 || log_wdata.size() != 1) begin bad++; $display("FAIL wdf_single: got cmds=%0d wdata=%0d want 1 1", log_cmd.size(), log_wdata.size()); end
        total++; if (log_wdata.size() > 0 && log_wdata[0] !== phrase(200)) begin bad++; $display("FAIL wdf_data: got %h want %h", log_wdata[0], phrase(200)); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        app_rdy = 1'b0;
        send_write(phrase(300), 1'b0);
        total++; if (app_en !== 1'b1 || app_addr !== 27'd8) begin bad++; $display("FAIL mid_pre: got en=%b addr=%0d want 1 8", app_en, app_addr); end
        #2;
        rst_n_in = 1'b0;
        #1;
        total++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0) begin bad++; $display("FAIL mid_reset_en: got en=%b wren=%b want 0 0", app_en, app_wdf_wren); end
        total++; if (app_addr !== 27'd0 || app_wdf_data !== 128'd0) begin bad++; $display("FAIL mid_reset_data: got addr=%0d data=%h want 0 0", app_addr, app_wdf_data); end
        total++; if (rd_valid_out !== 1'b0) begin bad++; $display("FAIL mid_reset_rd_valid: got %b want 0", rd_valid_out); end
        @(negedge clk_in);
        app_rdy = 1'b1;
        rst_n_in = 1'b1;
        clear_logs();
        rd_ready_in = 1'b1;
        send_write(phrase(400), 1'b0);
        repeat (40) @(negedge clk_in);
        total++;
        if (log_cmd.size() != 1 || log_cmd[0] !== 3'b000 || log_addr[0] !== 27'd0) begin
            bad++;
            $display("FAIL mid_restart: got %0d cmds first addr=%0d want 1 write at addr 0", log_cmd.size(), (log_addr.size() > 0) ? log_addr[0] : 27'h7FFFFFF);
        end
        total++; if (log_wdata.size() != 1 || log_wdata[0] !== phrase(400)) begin bad++; $display("FAIL mid_restart_data: got %0d entries want phrase 400", log_wdata.size()); end
    endtask

    initial begin
        test_reset();
        test_calib();
        test_stream();
        test_credit();
        test_pop_order();
        test_back_to_back();
        test_wdf_delay();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation time limit want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/framebuffer_mig_arbiter.md
# framebuffer_mig_arbiter

Sequences a single MIG user interface (app_*) between the camera write stream (128-bit phrases from the pixel packer) and the display read stream (128-bit phrases to the phrase digester). Owns frame-relative write and read address counters, round-robin arbitration of MIG commands, and a credit-limited read-return buffer so MIG read data, which cannot be back-pressured, is never dropped. It sits between the packer/digester pair and the DDR controller.

## Interface
- FRAME_PHRASES, 9600: phrases per frame (320x240 px / 8); counters wrap at FRAME_PHRASES-1.
- ADDR_STRIDE, 8: app_addr increment per phrase.
- RD_DEPTH, 16: read-return buffer depth; power of two, max outstanding-plus-buffered reads.
- clk_in  in  1  sole clock (MIG ui_clk).
- rst_n_in  in  1  asynchronous assert, active-low reset.
- calib_in  in  1  MIG init_calib_complete.
- wr_valid_in  in  1  write phrase valid.
- wr_ready_out  out  1  write phrase accepted this cycle.
- wr_data_in  in  128  write phrase.
- wr_tuser_in  in  1  phrase is first of a new frame.
- rd_valid_out  out  1  read phrase valid (buffer non-empty).
- rd_ready_in  in  1  consumer takes phrase.
- rd_data_out  out  128  read phrase (buffer head).
- rd_tuser_out  out  1  head phrase came from frame index 0.
- app_addr  out  27  MIG address = index*ADDR_STRIDE.
- app_cmd  out  3  3'b000 write, 3'b001 read.
- app_en  out  1  command valid.
- app_rdy  in  1  MIG accepts command.
- app_wdf_data  out  128  write data.
- app_wdf_wren, app_wdf_end  out  1  write data valid/last (always equal).
- app_wdf_mask  out  16  constant 0.
- app_wdf_rdy  in  1  MIG accepts write data.
- app_rd_data  in  128  returned read data.
- app_rd_data_valid  in  1  returned data valid; no back-pressure.

## Operation
- FSM states: WAIT_CAL, ARB, WR, RD. Reset -> WAIT_CAL; WAIT_CAL -> ARB when calib_in=1. calib_in falling in any state -> WAIT_CAL after current WR/RD completes.
- Requests in ARB: wr_req = wr_valid_in; rd_req = frame_ready && (outstanding + occupancy) < RD_DEPTH.
- frame_ready: 0 at reset; set on the first write-index wrap (FRAME_PHRASES-1 -> 0) or first accepted wr_tuser_in phrase after ≥1 prior write; never cleared except reset.
- Round-robin: both requesting -> grant the side not granted last (last_grant reset = read, so write wins first tie); single requester granted; none -> stay ARB.
- Write grant: wr_ready_out=1 for that one ARB cycle; latch wr_data_in, address. Index = 0 if wr_tuser_in else wr_idx; wr_idx <= index+1, wrapping to 0 after FRAME_PHRASES-1. -> WR.
- WR: app_en and app_wdf_wren held until each handshake (app_en&&app_rdy, wren&&app_wdf_rdy) has occurred; track cmd_done/data_done independently; both done -> ARB.
- Read grant: latch rd_idx address, push tag (rd_idx==0) into tag FIFO, outstanding++; rd_idx wraps like wr_idx. -> RD. RD: app_en held until app_rdy -> ARB.
- Return: each app_rd_data_valid writes app_rd_data plus popped tag into buffer, outstanding--. Pop on rd_valid_out && rd_ready_in. Same-cycle push and pop allowed. Overflow impossible by credit rule.
- Counters width $clog2(FRAME_PHRASES); outstanding/occupancy width $clog2(RD_DEPTH)+1.

## Timing
- Reset (async, rst_n_in=0): all outputs 0, app_cmd=0, buffers empty, indices 0, outstanding 0, state WAIT_CAL; takes effect immediately, mid-transaction commands abandoned.
- ARB decision is one cycle; min write or read command period 2 cycles (ARB + WR/RD with ready high).
- app_addr/app_cmd/app_wdf_data stable from WR/RD entry until respective handshake.
- rd_valid_out rises the cycle after app_rd_data_valid into an empty buffer; rd_data_out registered head.
- wr_ready_out never asserts outside ARB or while calib_in=0.

## Test plan
- Calib held low 50 cycles with wr_valid_in=1 -> wr_ready_out, app_en stay 0; calib_in rises -> first write at app_addr 0 within 2 cycles.
- Stream 9600 writes (tuser on first), app_rdy/app_wdf_rdy=1 -> addresses 0..76792 step 8, frame_ready set after wrap, next write at addr 0.
- app_wdf_rdy delayed 3 cycles after app_rdy -> app_en drops after cmd handshake, wren held until data handshake, single write issued.
- Both requesting continuously -> commands alternate W,R,W,R; first is W.
- rd_ready_in=0, MIG returns instantly -> exactly 16 reads issued then none; release ready -> reads resume, data order preserved, rd_tuser_out=1 only on index-0 phrase.
- Assert rst_n_in mid-WR -> outputs 0 same cycle; after release + calib, writes restart at addr 0.
